// File: rtl/dual_deque_arbiter.sv
// Round-robin arbiter sharing one dual_deque between two requesters, with full/empty
// screening before any strobe. Define DDQ_ARB_FIXED_PRIO_EN to make requester 0 win every tie.
module dual_deque_arbiter #(
  parameter int DATA_W  = 8,
  parameter int POP_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2:0]        req0_cmd,
  input  logic [2:0]        req1_cmd,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req1_data,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              dq_deque_select,
  output logic              dq_end_select,
  output logic              dq_push,
  output logic              dq_pop,
  output logic [DATA_W-1:0] dq_data_in,
  input  logic [DATA_W-1:0] dq_data_out,
  input  logic              d0_empty,
  input  logic              d0_full,
  input  logic              d1_empty,
  input  logic              d1_full,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] WAIT_INIT = (POP_LAT > 0) ? 2'(POP_LAT - 1) : 2'd0;

  state_t     state;
  logic       cur_op;
  logic       cur_grant;
  logic [1:0] wait_cnt;
`ifndef DDQ_ARB_FIXED_PRIO_EN
  logic       last_grant;
`endif

  logic              grant;
  logic              accept;
  logic [2:0]        sel_cmd;
  logic [DATA_W-1:0] sel_data;
  logic              sel_full;
  logic              sel_empty;
  logic              illegal;
  logic [1:0]        rsp_onehot;

  // Handshake: a command transfers on a cycle where req_valid[i] and req_ready[i] are both 1;
  // ready is only offered in IDLE, to at most one requester, and the requester holds valid until then.
  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
`ifdef DDQ_ARB_FIXED_PRIO_EN
      2'b11:   grant = 1'b0;
`else
      2'b11:   grant = ~last_grant;
`endif
      default: grant = 1'b0;
    endcase
  end

  assign accept    = (state == S_IDLE) && (req_valid != 2'b00);
  assign req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign sel_cmd   = grant ? req1_cmd  : req0_cmd;
  assign sel_data  = grant ? req1_data : req0_data;

  // The deque is only touched when the selected side can take the operation.
  assign sel_full   = dq_deque_select ? d1_full  : d0_full;
  assign sel_empty  = dq_deque_select ? d1_empty : d0_empty;
  assign illegal    = cur_op ? sel_empty : sel_full;
  assign dq_push    = (state == S_EXEC) && !cur_op && !sel_full;
  assign dq_pop     = (state == S_EXEC) &&  cur_op && !sel_empty;
  assign rsp_onehot = cur_grant ? 2'b10 : 2'b01;
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cur_op          <= 1'b0;
      cur_grant       <= 1'b0;
      wait_cnt        <= 2'd0;
`ifndef DDQ_ARB_FIXED_PRIO_EN
      last_grant      <= 1'b1;
`endif
      dq_deque_select <= 1'b0;
      dq_end_select   <= 1'b0;
      dq_data_in      <= '0;
      rsp_valid       <= 2'b00;
      rsp_data        <= '0;
      rsp_err         <= 1'b0;
    end else begin
      rsp_valid <= 2'b00;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cur_op          <= sel_cmd[2];
            cur_grant       <= grant;
            dq_deque_select <= sel_cmd[1];
            dq_end_select   <= sel_cmd[0];
            dq_data_in      <= sel_data;
            state           <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (illegal || !cur_op || (POP_LAT == 0)) begin
            rsp_valid       <= rsp_onehot;
            rsp_err         <= illegal;
            rsp_data        <= (cur_op && !illegal) ? dq_data_out : '0;
            dq_deque_select <= 1'b0;
            dq_end_select   <= 1'b0;
            dq_data_in      <= '0;
            state           <= S_RESP;
          end else begin
            wait_cnt <= WAIT_INIT;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 2'd0) begin
            rsp_valid       <= rsp_onehot;
            rsp_err         <= 1'b0;
            rsp_data        <= dq_data_out;
            dq_deque_select <= 1'b0;
            dq_end_select   <= 1'b0;
            dq_data_in      <= '0;
            state           <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        S_RESP: begin
`ifndef DDQ_ARB_FIXED_PRIO_EN
          last_grant <= cur_grant;
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_deque_arbiter.sv
// Bench for dual_deque_arbiter: behavioural dual deque on the strobe side, transaction-level
// reference and expected-response queue on the requester side.
module tb_dual_deque_arbiter;

  localparam int DATA_W  = 8;
  localparam int POP_LAT = 1;
  localparam int DEPTH   = 4;
  localparam int W       = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2:0]        req0_cmd, req1_cmd;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              dq_deque_select, dq_end_select, dq_push, dq_pop;
  logic [DATA_W-1:0] dq_data_in;
  logic [DATA_W-1:0] dq_data_out = 8'hEE;
  logic              d0_empty, d0_full, d1_empty, d1_full;
  logic [1:0]        dbg_state;

  dual_deque_arbiter #(.DATA_W(DATA_W), .POP_LAT(POP_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
    .req0_data(req0_data), .req1_data(req1_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dq_deque_select(dq_deque_select), .dq_end_select(dq_end_select),
    .dq_push(dq_push), .dq_pop(dq_pop),
    .dq_data_in(dq_data_in), .dq_data_out(dq_data_out),
    .d0_empty(d0_empty), .d0_full(d0_full), .d1_empty(d1_empty), .d1_full(d1_full),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural dual deque (front = end 0, back = end 1), one-cycle pop latency
  logic [7:0] m0[$], m1[$];
  int cnt0 = 0, cnt1 = 0;
  assign d0_empty = (cnt0 == 0);
  assign d0_full  = (cnt0 >= DEPTH);
  assign d1_empty = (cnt1 == 0);
  assign d1_full  = (cnt1 >= DEPTH);

  always @(posedge clk) begin : deque_model
    logic [7:0] v;
    v = 8'hEE;
    if (dq_push) begin
      if (dq_deque_select) begin
        if (dq_end_select) m1.push_back(dq_data_in); else m1.push_front(dq_data_in);
      end else begin
        if (dq_end_select) m0.push_back(dq_data_in); else m0.push_front(dq_data_in);
      end
    end
    if (dq_pop) begin
      if (dq_deque_select) begin
        if (m1.size() > 0) v = dq_end_select ? m1.pop_back() : m1.pop_front();
      end else begin
        if (m0.size() > 0) v = dq_end_select ? m0.pop_back() : m0.pop_front();
      end
    end
    dq_data_out <= v;
    cnt0 <= m0.size();
    cnt1 <= m1.size();
  end

  // scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  logic [7:0] r0[$], r1[$];
  logic       last_model = 1'b1;
  int         last_acc = -10;
  logic [7:0] exp_push_data = '0;
  int n_push_exp = 0, n_pop_exp = 0, n_push_seen = 0, n_pop_seen = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] last_rsp_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
  endtask

  function automatic logic exp_grant(input logic [1:0] v);
    case (v)
      2'b01: return 1'b0;
      2'b10: return 1'b1;
`ifdef DDQ_ARB_FIXED_PRIO_EN
      default: return 1'b0;
`else
      default: return ~last_model;
`endif
    endcase
  endfunction

  // transaction-level reference: computes the response for an accepted command
  task automatic predict(input logic g, input logic [2:0] cmd, input logic [7:0] data);
    logic err; logic [7:0] d; logic [3:0] lat;
    err = 1'b0; d = 8'h00; lat = 4'd2;
    if (!cmd[2]) begin
      if ((cmd[1] ? r1.size() : r0.size()) >= DEPTH) err = 1'b1;
      else begin
        n_push_exp++;
        exp_push_data = data;
        if (cmd[1]) begin if (cmd[0]) r1.push_back(data); else r1.push_front(data); end
        else        begin if (cmd[0]) r0.push_back(data); else r0.push_front(data); end
      end
    end else begin
      if ((cmd[1] ? r1.size() : r0.size()) == 0) err = 1'b1;
      else begin
        n_pop_exp++;
        lat = 4'(2 + POP_LAT);
        if (cmd[1]) d = cmd[0] ? r1.pop_back() : r1.pop_front();
        else        d = cmd[0] ? r0.pop_back() : r0.pop_front();
      end
    end
    exp_q.push_back({g, err, d, lat});
    acc_q.push_back(cyc);
    last_acc   = cyc;
    last_model = g;
  endtask

  // monitor: strobe rules and response scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e; int a;
    if (!rst) begin
      if (dq_push | dq_pop) begin
        check("strobe_excl", dq_push & dq_pop, 0);
        check("strobe_once", prev_strobe, 0);
        check("strobe_cyc", cyc, last_acc + 1);
        if (dq_push) begin
          n_push_seen++;
          check("push_data", dq_data_in, exp_push_data);
        end
        if (dq_pop) n_pop_seen++;
      end
      prev_strobe = dq_push | dq_pop;
      if (rsp_valid != 2'b00) begin
        if (exp_q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
        else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("rsp_valid", rsp_valid, e[13] ? 2 : 1);
          check("rsp_err", rsp_err, e[12]);
          check("rsp_data", rsp_data, e[11:4]);
          check("rsp_lat", cyc - a, e[3:0]);
          last_rsp_data = rsp_data;
        end
      end
    end else prev_strobe = 1'b0;
  end

  // driver tasks
  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
    check("idle_outs", {dq_deque_select, dq_end_select, dq_data_in, dq_push, dq_pop, dbg_state}, 0);
    check("rsp_hold", rsp_data, last_rsp_data);
  endtask

  task automatic issue(input int r, input logic [2:0] cmd, input logic [7:0] data);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    if (r == 0) begin req0_cmd = cmd; req0_data = data; end
    else        begin req1_cmd = cmd; req1_data = data; end
    req_valid = (r == 0) ? 2'b01 : 2'b10;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        ok = 1'b1;
        check("grant", req_ready, req_valid);
        predict(exp_grant(req_valid), cmd, data);
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!ok) check("accept_timeout", 1, 0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();
  endtask

  task automatic run_both();
    logic [1:0] v; int cnt; logic g;
    v = 2'b11; cnt = 0;
    @(posedge clk); #1;
    req0_cmd = 3'b011; req1_cmd = 3'b011;
    req0_data = 8'($urandom_range(0, 255));
    req1_data = 8'($urandom_range(0, 255));
    req_valid = v;
    for (int i = 0; i < 100 && v != 2'b00; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        g = exp_grant(v);
        check("rr_grant", req_ready, g ? 2 : 1);
        predict(g, g ? req1_cmd : req0_cmd, g ? req1_data : req0_data);
        cnt++;
        @(posedge clk); #1;
        if (cnt >= 4) v[g] = 1'b0;
        else if (g) req1_data = 8'($urandom_range(0, 255));
        else        req0_data = 8'($urandom_range(0, 255));
        req_valid = v;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (v != 2'b00) check("both_timeout", v, 0);
    req_valid = 2'b00;
    drain();
  endtask

  initial begin
    logic ok;
    rst = 1'b1; req_valid = 2'b00;
    req0_cmd = '0; req1_cmd = '0; req0_data = '0; req1_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {req_ready, rsp_valid, rsp_data, rsp_err, dq_deque_select, dq_end_select,
                         dq_push, dq_pop, dq_data_in, dbg_state}, 0);
    rst = 1'b0;

    issue(0, 3'b000, 8'hA5);               // push deque0 front
    issue(1, 3'b100, 8'h00);               // pop deque0 front -> A5
    issue(0, 3'b110, 8'h00);               // pop empty deque1 -> error
    for (int i = 0; i < DEPTH; i++) issue(i % 2, 3'b001, 8'(8'h10 + i));
    issue(1, 3'b001, 8'h77);               // push to full deque0 -> error

    // reset while waiting on pop data: abandoned, no response
    ok = 1'b0;
    @(posedge clk); #1;
    req0_cmd = 3'b101; req_valid = 2'b01;
    @(negedge clk);
    if (req_ready == 2'b01) begin
      ok = 1'b1;
      predict(1'b0, 3'b101, 8'h00);
    end
    check("rst_accept", ok, 1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    check("in_wait", dbg_state, 2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outs", {req_ready, rsp_valid, rsp_data, rsp_err, dq_deque_select, dq_end_select,
                           dq_push, dq_pop, dq_data_in, dbg_state}, 0);
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    last_model = 1'b1;
    last_rsp_data = 8'h00;
    repeat (4) @(negedge clk);

    run_both();                            // contention straight after reset

    for (int i = 0; i < 24; i++)
      issue($urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));

    check("push_count", n_push_seen, n_push_exp);
    check("pop_count", n_pop_seen, n_pop_exp);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
